demux_8x16_reg: RTL and testbench

DEMUX_8X16_REG -- requirements
Module: demux_8x16_reg

---
 rtl/demux_8x16_reg.sv | 134 +++++++++++++
 tb/tb_demux_8x16_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_8x16_reg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_8x16_reg
//  Description : Registered 1-to-8 demultiplexer for 16-bit words. Each of
//                the eight output slots holds one word plus a valid flag.
//                Downstream frees a slot by pulsing its clr bit. A write is
//                accepted only when the addressed slot is empty, and an
//                8-bit counter tracks accepted writes.
//
//  Optional feature (compile-time macro DEMUX_BCAST_EN):
//                When defined, asserting bcast with in_valid requests a write
//                of data_in to all eight slots. This write is accepted only
//                when every slot is empty, and s is ignored. When the macro
//                is not defined, bcast is ignored.
//
//  Ports:
//    clk        in   1   clock, rising-edge active
//    reset      in   1   synchronous active-high reset
//    s          in   3   destination slot select
//    data_in    in  16   word to write
//    in_valid   in   1   write request
//    in_ready   out  1   addressed slot (or all slots for broadcast) empty
//    clr        in   8   per-slot consume pulse, bit n frees slot n
//    bcast      in   1   broadcast request (DEMUX_BCAST_EN builds only)
//    out0..out7 out 16   registered slot contents
//    out_valid  out  8   bit n set while slot n holds an unconsumed word
//    wr_count   out  8   accepted-write counter, wraps 8'hFF -> 8'h00
//
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_8x16_reg #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  s,
    input  logic [15:0] data_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  clr,
    input  logic        bcast,
    output logic [15:0] out0,
    output logic [15:0] out1,
    output logic [15:0] out2,
    output logic [15:0] out3,
    output logic [15:0] out4,
    output logic [15:0] out5,
    output logic [15:0] out6,
    output logic [15:0] out7,
    output logic [7:0]  out_valid,
    output logic [7:0]  wr_count
);

    localparam logic [7:0] c_NO_SLOTS  = 8'h00;
    localparam logic [7:0] c_ALL_SLOTS = 8'hFF;
    localparam logic [7:0] c_ONE_SLOT  = 8'h01;

    logic [15:0] r_data [8];
    logic [7:0]  r_valid;
    logic [7:0]  r_wr_count;

    logic        w_bcast_sel;
    logic        w_ready;
    logic        w_accept;
    logic [7:0]  w_wr_mask;

`ifdef DEMUX_BCAST_EN
    assign w_bcast_sel = bcast;
`else
    // Broadcast is not built in: the request pin is intentionally left idle.
    logic w_unused_bcast;
    assign w_unused_bcast = bcast;
    assign w_bcast_sel    = 1'b0;
`endif

    // Readiness looks at the registered flags only. A clr that arrives in
    // the same cycle does not make a slot writable until the next cycle.
    always_comb begin
        w_ready   = 1'b0;
        w_accept  = 1'b0;
        w_wr_mask = c_NO_SLOTS;
        if (w_bcast_sel) begin
            w_ready = (r_valid == c_NO_SLOTS);
        end else begin
            w_ready = ~r_valid[s];
        end
        w_accept = in_valid & w_ready;
        if (w_accept) begin
            w_wr_mask = w_bcast_sel ? c_ALL_SLOTS : (c_ONE_SLOT << s);
        end
    end

    assign in_ready = w_ready;

    // Flags: clr drops a flag and a write sets it. A write applied in the
    // same cycle takes precedence because its OR is applied after the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= c_NO_SLOTS;
            r_wr_count <= 8'h00;
        end else begin
            r_valid <= (r_valid & ~clr) | w_wr_mask;
            if (w_accept) begin
                r_wr_count <= r_wr_count + 8'h01;
            end
        end
    end

    // Data registers: clr does not change the stored data.
    generate
        for (genvar g = 0; g < 8; g++) begin : g_slot
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_data[g] <= RESET_VAL;
                end else if (w_wr_mask[g]) begin
                    r_data[g] <= data_in;
                end
            end
        end
    endgenerate

    assign out0      = r_data[0];
    assign out1      = r_data[1];
    assign out2      = r_data[2];
    assign out3      = r_data[3];
    assign out4      = r_data[4];
    assign out5      = r_data[5];
    assign out6      = r_data[6];
    assign out7      = r_data[7];
    assign out_valid = r_valid;
    assign wr_count  = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_demux_8x16_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_8x16_reg
//  Description : Scoreboard testbench for demux_8x16_reg. A reference model
//                of slot contents, flags and write count produces the
//                expected in_ready value for each cycle and the expected
//                state after each edge. Independent monitors compare these
//                expectations with the DUT outputs.
//                The testbench honours DEMUX_BCAST_EN in the same way as the
//                design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_8x16_reg;

    localparam logic [15:0] c_RST_VAL = 16'h5A3C;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  s;
    logic [15:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  clr;
    logic        bcast;
    logic [15:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0]  out_valid;
    logic [7:0]  wr_count;

    demux_8x16_reg #(.RESET_VAL(c_RST_VAL)) dut (
        .clk(clk), .reset(reset), .s(s), .data_in(data_in),
        .in_valid(in_valid), .in_ready(in_ready), .clr(clr), .bcast(bcast),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7),
        .out_valid(out_valid), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Expected state after one clock edge.
    typedef struct packed {
        logic [127:0] data;
        logic [7:0]   valid;
        logic [7:0]   cnt;
    } state_t;

    state_t      state_q[$];
    logic        ready_q[$];

    int          total  = 0;
    int          passed = 0;

    // Reference model contents.
    logic [15:0] m_data [8];
    logic [7:0]  m_valid;
    logic [7:0]  m_cnt;

    logic [15:0] dut_out [8];
    assign dut_out[0] = out0; assign dut_out[1] = out1;
    assign dut_out[2] = out2; assign dut_out[3] = out3;
    assign dut_out[4] = out4; assign dut_out[5] = out5;
    assign dut_out[6] = out6; assign dut_out[7] = out7;

`ifdef DEMUX_BCAST_EN
    localparam bit c_BCAST_EN = 1'b1;
`else
    localparam bit c_BCAST_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Apply one cycle of stimulus and update the reference model.
    task automatic step(input logic rst, input logic iv, input logic [2:0] ss,
                        input logic [15:0] d, input logic [7:0] c, input logic b);
        logic   rdy;
        logic   all_empty;
        state_t st;
        @(negedge clk);
        reset = rst; in_valid = iv; s = ss; data_in = d; clr = c; bcast = b;
        all_empty = 1'b1;
        for (int n = 0; n < 8; n++) if (m_valid[n]) all_empty = 1'b0;
        if (c_BCAST_EN && b) rdy = all_empty;
        else                 rdy = !m_valid[ss];
        ready_q.push_back(rdy);
        if (rst) begin
            for (int n = 0; n < 8; n++) m_data[n] = c_RST_VAL;
            m_valid = 8'h00;
            m_cnt   = 8'h00;
        end else begin
            for (int n = 0; n < 8; n++) if (c[n]) m_valid[n] = 1'b0;
            if (iv && rdy) begin
                for (int n = 0; n < 8; n++) begin
                    if ((c_BCAST_EN && b) || n == int'(ss)) begin
                        m_data[n]  = d;
                        m_valid[n] = 1'b1;
                    end
                end
                m_cnt = 8'((int'(m_cnt) + 1) % 256);
            end
        end
        for (int n = 0; n < 8; n++) st.data[n*16 +: 16] = m_data[n];
        st.valid = m_valid;
        st.cnt   = m_cnt;
        state_q.push_back(st);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
    endtask

    // Monitor: combinational in_ready in the middle of the low phase.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (ready_q.size() > 0) check("in_ready", {31'd0, in_ready}, {31'd0, ready_q.pop_front()});
        end
    end

    // Monitor: registered state just after each rising edge.
    initial begin
        state_t e;
        forever begin
            @(posedge clk);
            #1;
            if (state_q.size() > 0) begin
                e = state_q.pop_front();
                check("out_valid", {24'd0, out_valid}, {24'd0, e.valid});
                check("wr_count",  {24'd0, wr_count},  {24'd0, e.cnt});
                for (int n = 0; n < 8; n++)
                    check($sformatf("out%0d", n), {16'd0, dut_out[n]}, {16'd0, e.data[n*16 +: 16]});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; s = 3'd0; data_in = 16'h0; clr = 8'h0; bcast = 1'b0;
        for (int n = 0; n < 8; n++) m_data[n] = 16'hxxxx;
        m_valid = 8'hxx; m_cnt = 8'hxx;

        // Reset, then write A5A5 to slot 3.
        step(1'b1, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
        step(1'b0, 1'b1, 3'd3, 16'hA5A5, 8'h00, 1'b0);
        @(posedge clk); #1;
        check("vec_out3",  {16'd0, out3}, 32'h0000A5A5);
        check("vec_valid", {24'd0, out_valid}, 32'h08);
        check("vec_count", {24'd0, wr_count}, 32'h01);
        check("vec_out0",  {16'd0, out0}, {16'd0, c_RST_VAL});

        // Write to a full slot is held off.
        step(1'b0, 1'b1, 3'd3, 16'h1234, 8'h00, 1'b0);
        // Same-cycle clr does not open the slot.
        step(1'b0, 1'b1, 3'd3, 16'h1234, 8'h08, 1'b0);
        step(1'b0, 1'b1, 3'd3, 16'h1234, 8'h00, 1'b0);
        // Clr on an empty slot has no effect.
        step(1'b0, 1'b0, 3'd0, 16'h0000, 8'h80, 1'b0);

        // Slot 5 full, then clr[5] with a blocked write. Free the slot and
        // rewrite it while clr[5] is asserted, so the write wins.
        step(1'b0, 1'b1, 3'd5, 16'h7777, 8'h00, 1'b0);
        step(1'b0, 1'b1, 3'd5, 16'hBEEF, 8'h20, 1'b0);
        step(1'b0, 1'b1, 3'd5, 16'hBEEF, 8'h20, 1'b0);
        @(posedge clk); #1;
        check("vec_out5",   {16'd0, out5}, 32'h0000BEEF);
        check("vec_valid5", {31'd0, out_valid[5]}, 32'd1);

        // Multiple clr bits in one cycle.
        step(1'b0, 1'b0, 3'd0, 16'h0000, 8'hFF, 1'b0);

        // Issue 256 accepted writes so the counter wraps back to zero.
        step(1'b1, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0);
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b1, 3'(i), 16'(i * 16'h0101), 8'h00, 1'b0);
            step(1'b0, 1'b0, 3'd0, 16'h0000, 8'hFF, 1'b0);
        end
        @(posedge clk); #1;
        check("vec_wrap", {24'd0, wr_count}, 32'h00);

        // Reset asserted in the same cycle as an accepted write.
        step(1'b0, 1'b1, 3'd1, 16'h1111, 8'h00, 1'b0);
        step(1'b1, 1'b1, 3'd0, 16'hCAFE, 8'h00, 1'b0);
        @(posedge clk); #1;
        check("vec_rst_out0",  {16'd0, out0}, {16'd0, c_RST_VAL});
        check("vec_rst_valid", {24'd0, out_valid}, 32'h00);
        check("vec_rst_count", {24'd0, wr_count}, 32'h00);
        step(1'b0, 1'b1, 3'd0, 16'hCAFE, 8'h00, 1'b0);

`ifdef DEMUX_BCAST_EN
        // Broadcast to all empty slots, then a blocked broadcast.
        step(1'b0, 1'b0, 3'd0, 16'h0000, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 3'd6, 16'h00FF, 8'h00, 1'b1);
        @(posedge clk); #1;
        check("vec_bc_valid", {24'd0, out_valid}, 32'hFF);
        check("vec_bc_out7",  {16'd0, out7}, 32'h000000FF);
        step(1'b0, 1'b0, 3'd0, 16'h0000, 8'hFE, 1'b0);
        step(1'b0, 1'b1, 3'd2, 16'h0F0F, 8'h00, 1'b1);
`else
        // Without broadcast support, bcast behaves as a single-slot write.
        step(1'b0, 1'b0, 3'd0, 16'h0000, 8'hFF, 1'b0);
        step(1'b0, 1'b1, 3'd6, 16'h00FF, 8'h00, 1'b1);
        @(posedge clk); #1;
        check("vec_nobc_valid", {24'd0, out_valid}, 32'h40);
`endif

        // Random traffic, with s changed freely and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 3'($urandom),
                 16'($urandom),
                 8'($urandom & $urandom & $urandom),
                 ($urandom_range(0, 7) == 0));
        end

        idle();
        idle();
        @(posedge clk); #3;
        check("sb_state_drained", state_q.size(), 32'd0);
        check("sb_ready_drained", ready_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
